// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered one-hot grant and hold timeout.
// Optional ARB_LOCK_EN adds a lock input that suppresses timeout rotation while asserted.

// state | meaning
// IDLE  | no grant outstanding, gnt all-zero
// GRANT | gnt_idx owns the resource, hold_cnt counts its consecutive cycles
module rr_arbiter_4 #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
`ifdef ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t     state, state_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [7:0] hold_cnt, hold_nxt;
    logic [1:0] idx_nxt;
    logic [3:0] gnt_nxt;
    logic       valid_nxt;
    logic [3:0] others;
    logic       lock_hold;
    logic       issue;
    logic [1:0] win;

    // Priority runs ptr, ptr+1, ptr+2, ptr+3; scanning backwards lets the first hit win.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = p;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) pick = idx;
        end
        return pick;
    endfunction

`ifdef ARB_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    assign others = req & ~(4'b0001 << gnt_idx);

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        hold_nxt  = hold_cnt;
        idx_nxt   = gnt_idx;
        gnt_nxt   = gnt;
        valid_nxt = gnt_valid;
        issue     = 1'b0;
        win       = ptr;

        case (state)
            IDLE: begin
                if (|req) begin
                    issue = 1'b1;
                    win   = rr_pick(req, ptr);
                end
            end
            GRANT: begin
                if (!req[gnt_idx]) begin
                    if (|others) begin
                        issue = 1'b1;
                        win   = rr_pick(others, ptr);
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = 4'b0000;
                        valid_nxt = 1'b0;
                    end
                end else if (hold_cnt == HOLD_LAST && (|others) && !lock_hold) begin
                    issue = 1'b1;
                    win   = rr_pick(others, ptr);
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_nxt = hold_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (issue) begin
            state_nxt = GRANT;
            idx_nxt   = win;
            gnt_nxt   = 4'b0001 << win;
            valid_nxt = 1'b1;
            hold_nxt  = 8'd0;
            ptr_nxt   = win + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            hold_cnt  <= 8'd0;
            gnt_idx   <= 2'd0;
            gnt       <= 4'b0000;
            gnt_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_nxt;
            gnt_idx   <= idx_nxt;
            gnt       <= gnt_nxt;
            gnt_valid <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Scoreboard bench for rr_arbiter_4: stimulus queues expected grants per cycle,
// a negedge monitor pops and compares them against the registered outputs.
module tb_rr_arbiter_4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       lock = 1'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         when;
        logic [3:0] g;
        logic [1:0] idx;
        logic       v;
        string      name;
    } exp_t;

    exp_t q[$];

    rr_arbiter_4 #(.HOLD_MAX(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
`ifdef ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Apply inputs, let one rising edge sample them, settle just after it.
    task automatic drive(input logic [3:0] r, input logic rn);
        req   = r;
        rst_n = rn;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic [3:0] g, input logic [1:0] idx,
                              input logic v, input string name);
        exp_t e;
        e.when = cyc;
        e.g    = g;
        e.idx  = idx;
        e.v    = v;
        e.name = name;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        total++;
        if (!$onehot0(gnt)) begin
            bad++;
            $display("FAIL onehot @%0d: gnt=%b, required at most one bit set", cyc, gnt);
        end
        while (q.size() > 0 && q[0].when <= cyc) begin
            e = q.pop_front();
            total++;
            if (e.when != cyc || gnt !== e.g || gnt_idx !== e.idx || gnt_valid !== e.v) begin
                bad++;
                $display("FAIL %s @%0d: got gnt=%b idx=%0d valid=%b, want gnt=%b idx=%0d valid=%b",
                         e.name, e.when, gnt, gnt_idx, gnt_valid, e.g, e.idx, e.v);
            end
        end
    end

    initial begin
        int o;
        // Reset held two cycles with all requests up
        drive(4'b1111, 1'b0); expect_out(4'b0000, 2'd0, 1'b0, "rst_a");
        drive(4'b1111, 1'b0); expect_out(4'b0000, 2'd0, 1'b0, "rst_b");
        drive(4'b1111, 1'b1); expect_out(4'b0001, 2'd0, 1'b1, "rst_release");

        // Full contention: each owner exactly 8 cycles, no gaps
        for (int n = 1; n < 40; n++) begin
            o = (n / 8) % 4;
            drive(4'b1111, 1'b1);
            expect_out(4'b0001 << o, 2'(o), 1'b1, "round_robin");
        end

        // Handover 2 -> 3 -> 0 (wrap), then idle
        drive(4'b0000, 1'b0); expect_out(4'b0000, 2'd0, 1'b0, "rst_c");
        drive(4'b0100, 1'b1); expect_out(4'b0100, 2'd2, 1'b1, "owner2");
        drive(4'b1001, 1'b1); expect_out(4'b1000, 2'd3, 1'b1, "handover3");
        drive(4'b0001, 1'b1); expect_out(4'b0001, 2'd0, 1'b1, "handover_wrap");
        drive(4'b0000, 1'b1); expect_out(4'b0000, 2'd0, 1'b0, "release_idle");

        // Lone requester keeps grant past the hold limit
        for (int n = 0; n < 20; n++) begin
            drive(4'b0010, 1'b1);
            expect_out(4'b0010, 2'd1, 1'b1, "single_hold");
        end
        drive(4'b0000, 1'b1); expect_out(4'b0000, 2'd1, 1'b0, "single_drop");

        // Mid-grant reset: ptr returns to 0 so requester 1 beats 2
        drive(4'b0010, 1'b1); expect_out(4'b0010, 2'd1, 1'b1, "mid_owner1");
        for (int n = 0; n < 5; n++) begin
            drive(4'b0010, 1'b1);
            expect_out(4'b0010, 2'd1, 1'b1, "mid_hold");
        end
        drive(4'b0110, 1'b0); expect_out(4'b0000, 2'd0, 1'b0, "mid_reset");
        drive(4'b0110, 1'b1); expect_out(4'b0010, 2'd1, 1'b1, "mid_after");

        // Owner releases as a new request arrives the same edge
        drive(4'b1000, 1'b1); expect_out(4'b1000, 2'd3, 1'b1, "simul_release");
        // Re-raise by 3 while 0 waits: 0 must be served before 3 again
        drive(4'b1001, 1'b1); expect_out(4'b1000, 2'd3, 1'b1, "hold3");
        drive(4'b0001, 1'b1); expect_out(4'b0001, 2'd0, 1'b1, "to0");
        drive(4'b1001, 1'b1); expect_out(4'b0001, 2'd0, 1'b1, "reraise_waits");

`ifdef ARB_LOCK_EN
        drive(4'b0000, 1'b0); expect_out(4'b0000, 2'd0, 1'b0, "lock_rst");
        lock = 1'b1;
        drive(4'b0011, 1'b1); expect_out(4'b0001, 2'd0, 1'b1, "lock_owner0");
        for (int n = 0; n < 20; n++) begin
            drive(4'b0011, 1'b1);
            expect_out(4'b0001, 2'd0, 1'b1, "lock_hold");
        end
        lock = 1'b0;
        drive(4'b0011, 1'b1); expect_out(4'b0010, 2'd1, 1'b1, "lock_release");
`endif

        drive(4'b0000, 1'b1);
        drive(4'b0000, 1'b1);
        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
